// File: rtl/spi_master_xfer.sv
// SPI mode-0 master: one DATA_W-bit full-duplex transfer per accepted start, MSB first.
// Optional build macro SPI_MASTER_LOOPBACK_EN adds a loopback input that samples the internal mosi.
module spi_master_xfer #(
    parameter int CLK_DIV = 4,
    parameter int DATA_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              sclk,
    output logic              cs_n,
    output logic              mosi,
    input  logic              miso
`ifdef SPI_MASTER_LOOPBACK_EN
    ,
    input  logic              loopback
`endif
);

    localparam int CNT_W  = $clog2(CLK_DIV + 1);
    localparam int HALF_W = $clog2(2 * DATA_W);

    localparam logic [CNT_W-1:0]  CNT_LAST       = CNT_W'(CLK_DIV - 1);
    localparam logic [HALF_W-1:0] HALF_LAST      = HALF_W'(2 * DATA_W - 1);
    localparam logic [HALF_W-1:0] HALF_FALL_LAST = HALF_W'(2 * DATA_W - 2);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD
    } state_t;

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [HALF_W-1:0]   half_reg, half_next;
    logic [DATA_W-1:0]   tx_shift_reg, tx_shift_next;
    logic [DATA_W-1:0]   rx_shift_reg, rx_shift_next;
    logic [DATA_W-1:0]   rx_data_reg, rx_data_next;
    logic                sclk_reg, sclk_next;
    logic                cs_n_reg, cs_n_next;
    logic                mosi_reg, mosi_next;
    logic                busy_reg, busy_next;
    logic                done_reg, done_next;

    logic                miso_meta_reg;
    logic                miso_sync_reg;
    logic                sample_bit;
    logic                phase_end;
    logic [DATA_W-1:0]   tx_shifted;
    logic [DATA_W-1:0]   rx_shifted;

    // miso comes from another clock domain; two flops before it is used
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miso_meta_reg <= 1'b0;
            miso_sync_reg <= 1'b0;
        end else begin
            miso_meta_reg <= miso;
            miso_sync_reg <= miso_meta_reg;
        end
    end

`ifdef SPI_MASTER_LOOPBACK_EN
    assign sample_bit = loopback ? mosi_reg : miso_sync_reg;
`else
    assign sample_bit = miso_sync_reg;
`endif

    assign phase_end  = (cnt_reg == CNT_LAST);
    assign tx_shifted = tx_shift_reg << 1;
    assign rx_shifted = (rx_shift_reg << 1) | DATA_W'(sample_bit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            half_reg     <= '0;
            tx_shift_reg <= '0;
            rx_shift_reg <= '0;
            rx_data_reg  <= '0;
            sclk_reg     <= 1'b0;
            cs_n_reg     <= 1'b1;
            mosi_reg     <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            half_reg     <= half_next;
            tx_shift_reg <= tx_shift_next;
            rx_shift_reg <= rx_shift_next;
            rx_data_reg  <= rx_data_next;
            sclk_reg     <= sclk_next;
            cs_n_reg     <= cs_n_next;
            mosi_reg     <= mosi_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = phase_end ? '0 : cnt_reg + CNT_W'(1);
        half_next     = half_reg;
        tx_shift_next = tx_shift_reg;
        rx_shift_next = rx_shift_reg;
        rx_data_next  = rx_data_reg;
        sclk_next     = sclk_reg;
        cs_n_next     = cs_n_reg;
        mosi_next     = mosi_reg;
        busy_next     = busy_reg;
        done_next     = 1'b0;

        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (start) begin
                    state_next    = SETUP;
                    tx_shift_next = tx_data;
                    mosi_next     = tx_data[DATA_W-1];
                    rx_shift_next = '0;
                    half_next     = '0;
                    cs_n_next     = 1'b0;
                    busy_next     = 1'b1;
                end
            end
            SETUP: begin
                // The first sclk rise coincides with entering SHIFT, so it samples here
                if (phase_end) begin
                    state_next    = SHIFT;
                    sclk_next     = 1'b1;
                    half_next     = '0;
                    rx_shift_next = rx_shifted;
                end
            end
            SHIFT: begin
                if (phase_end) begin
                    if (half_reg == HALF_LAST) begin
                        state_next = HOLD;
                    end else begin
                        half_next = half_reg + HALF_W'(1);
                        sclk_next = ~sclk_reg;
                        if (!sclk_reg) begin
                            rx_shift_next = rx_shifted;
                        end else if (half_reg != HALF_FALL_LAST) begin
                            // The final fall leaves the last bit on mosi through HOLD
                            tx_shift_next = tx_shifted;
                            mosi_next     = tx_shifted[DATA_W-1];
                        end
                    end
                end
            end
            HOLD: begin
                if (phase_end) begin
                    state_next   = IDLE;
                    cs_n_next    = 1'b1;
                    mosi_next    = 1'b0;
                    busy_next    = 1'b0;
                    done_next    = 1'b1;
                    rx_data_next = rx_shift_reg;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign rx_data = rx_data_reg;
    assign sclk    = sclk_reg;
    assign cs_n    = cs_n_reg;
    assign mosi    = mosi_reg;

endmodule
